// File: rtl/calc_1.sv
`default_nettype none
// ============================================================================
// calc_1 : four-port 32-bit calculator sharing one add/sub and one shift unit
// Rev 1.0
// ============================================================================
module calc_1 (
  input  logic        c_clk,
  input  logic [1:7]  reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp4
);

  localparam int         NPORTS   = 4;
  localparam logic [3:0] CMD_NOP  = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;
  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OP2       = 2'd1,
    WAIT_UNIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  logic rst;
  assign rst = |reset;

  logic [3:0]  cmd_in  [NPORTS];
  logic [31:0] data_in [NPORTS];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  state_t      state  [NPORTS];
  logic [3:0]  cmd_q  [NPORTS];
  logic [31:0] op1_q  [NPORTS];
  logic [31:0] op2_q  [NPORTS];
  logic [1:0]  resp_q [NPORTS];
  logic [31:0] data_q [NPORTS];

  assign out_data1 = data_q[0];
  assign out_data2 = data_q[1];
  assign out_data3 = data_q[2];
  assign out_data4 = data_q[3];
  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];

  function automatic logic is_addsub(input logic [3:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB);
  endfunction

  function automatic logic is_shift(input logic [3:0] c);
    return (c == CMD_SHL) || (c == CMD_SHR);
  endfunction

  // Per-port unit requests, only raised once both operands are held.
  logic [NPORTS-1:0] want_as;
  logic [NPORTS-1:0] want_sh;

  always_comb begin
    want_as = '0;
    want_sh = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (state[p] == WAIT_UNIT) begin
        want_as[p] = is_addsub(cmd_q[p]);
        want_sh[p] = is_shift(cmd_q[p]);
      end
    end
  end

  // Fixed priority: scanning downwards lets the lowest-numbered port win.
  logic       as_valid;
  logic [1:0] as_sel;
  logic       sh_valid;
  logic [1:0] sh_sel;

  always_comb begin
    as_valid = 1'b0;
    as_sel   = 2'd0;
    sh_valid = 1'b0;
    sh_sel   = 2'd0;
    for (int p = NPORTS - 1; p >= 0; p--) begin
      if (want_as[p]) begin
        as_valid = 1'b1;
        as_sel   = p[1:0];
      end
      if (want_sh[p]) begin
        sh_valid = 1'b1;
        sh_sel   = p[1:0];
      end
    end
  end

  // Shared add/subtract unit; bit 32 is carry-out on add and borrow on sub.
  logic [31:0] as_a;
  logic [31:0] as_b;
  logic        as_sub;
  logic [32:0] as_full;
  logic        as_err;

  assign as_a    = op1_q[as_sel];
  assign as_b    = op2_q[as_sel];
  assign as_sub  = (cmd_q[as_sel] == CMD_SUB);
  assign as_full = as_sub ? ({1'b0, as_a} - {1'b0, as_b})
                          : ({1'b0, as_a} + {1'b0, as_b});
  assign as_err  = as_full[32];

  // Shared shift unit; only the low five bits of operand 2 are meaningful.
  logic [31:0] sh_a;
  logic [4:0]  sh_amt;
  logic        sh_left;
  logic [31:0] sh_res;

  assign sh_a    = op1_q[sh_sel];
  assign sh_amt  = op2_q[sh_sel][4:0];
  assign sh_left = (cmd_q[sh_sel] == CMD_SHL);
  assign sh_res  = sh_left ? (sh_a << sh_amt) : (sh_a >> sh_amt);

  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NPORTS; p++) begin
        state[p]  <= IDLE;
        cmd_q[p]  <= CMD_NOP;
        op1_q[p]  <= '0;
        op2_q[p]  <= '0;
        resp_q[p] <= RESP_NONE;
        data_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        case (state[p])
          IDLE: begin
            if (cmd_in[p] != CMD_NOP) begin
              cmd_q[p] <= cmd_in[p];
              op1_q[p] <= data_in[p];
              state[p] <= OP2;
            end
          end

          OP2: begin
            op2_q[p] <= data_in[p];
            state[p] <= WAIT_UNIT;
          end

          WAIT_UNIT: begin
            if (!is_addsub(cmd_q[p]) && !is_shift(cmd_q[p])) begin
              resp_q[p] <= RESP_ERR;
              data_q[p] <= '0;
              state[p]  <= RESP;
            end else if (as_valid && (as_sel == p[1:0]) && is_addsub(cmd_q[p])) begin
              resp_q[p] <= as_err ? RESP_ERR : RESP_OK;
              data_q[p] <= as_err ? 32'd0 : as_full[31:0];
              state[p]  <= RESP;
            end else if (sh_valid && (sh_sel == p[1:0]) && is_shift(cmd_q[p])) begin
              resp_q[p] <= RESP_OK;
              data_q[p] <= sh_res;
              state[p]  <= RESP;
            end
          end

          RESP: begin
            // The clearing edge may already accept the next command.
            resp_q[p] <= RESP_NONE;
            data_q[p] <= '0;
            if (cmd_in[p] != CMD_NOP) begin
              cmd_q[p] <= cmd_in[p];
              op1_q[p] <= data_in[p];
              state[p] <= OP2;
            end else begin
              state[p] <= IDLE;
            end
          end

          default: state[p] <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_1.sv
`default_nettype none
// ============================================================================
// tb_calc_1 : vector table plus scoreboard bench for calc_1
// Rev 1.0
// ============================================================================
module tb_calc_1;

  logic c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  logic [1:7]  reset;
  logic [0:3]  cmd_d [4];
  logic [0:31] dat_d [4];
  logic [0:31] out_data1, out_data2, out_data3, out_data4;
  logic [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;
  logic [0:31] dout [4];
  logic [0:1]  rsp  [4];

  assign dout[0] = out_data1;
  assign dout[1] = out_data2;
  assign dout[2] = out_data3;
  assign dout[3] = out_data4;
  assign rsp[0]  = out_resp1;
  assign rsp[1]  = out_resp2;
  assign rsp[2]  = out_resp3;
  assign rsp[3]  = out_resp4;

  calc_1 dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd_d[0]),
    .req1_data_in (dat_d[0]),
    .req2_cmd_in  (cmd_d[1]),
    .req2_data_in (dat_d[1]),
    .req3_cmd_in  (cmd_d[2]),
    .req3_data_in (dat_d[2]),
    .req4_cmd_in  (cmd_d[3]),
    .req4_data_in (dat_d[3]),
    .out_data1    (out_data1),
    .out_resp1    (out_resp1),
    .out_data2    (out_data2),
    .out_resp2    (out_resp2),
    .out_data3    (out_data3),
    .out_resp3    (out_resp3),
    .out_data4    (out_data4),
    .out_resp4    (out_resp4)
  );

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[14];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] pend_op2 [4];
  bit          pend_v   [4];

  always @(posedge c_clk) cyc <= cyc + 1;

  // Every response the DUT presents must match the oldest expectation for its port.
  always @(negedge c_clk) begin : mon
    int idx;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rsp[p] != 2'd0) begin
        idx = -1;
        for (int j = 0; j < sb.size(); j++)
          if (idx < 0 && sb[j].port == p) idx = j;
        if (idx < 0) begin
          errors++;
          $display("FAIL unexpected_resp port%0d: got resp %0d data %h at cycle %0d, required no response",
                   p + 1, rsp[p], dout[p], cyc);
        end else begin
          if (rsp[p] != sb[idx].resp || dout[p] != sb[idx].data || cyc != sb[idx].cyc) begin
            errors++;
            $display("FAIL resp_port%0d: got resp %0d data %h cycle %0d, required resp %0d data %h cycle %0d",
                     p + 1, rsp[p], dout[p], cyc, sb[idx].resp, sb[idx].data, sb[idx].cyc);
          end
          sb.delete(idx);
        end
      end else if (dout[p] != 32'd0) begin
        errors++;
        $display("FAIL idle_data_port%0d: got data %h with resp 0, required 0", p + 1, dout[p]);
      end
    end
  end

  task automatic start(input int p, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed,
                       input int lat, input bit track);
    cmd_d[p]    = c;
    dat_d[p]    = a;
    pend_op2[p] = b;
    pend_v[p]   = 1'b1;
    if (track) sb.push_back('{port: p, resp: er, data: ed, cyc: cyc + 3 + lat});
  endtask

  task automatic operand2();
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin
      if (pend_v[p]) begin
        cmd_d[p]  = 4'd0;
        dat_d[p]  = pend_op2[p];
        pend_v[p] = 1'b0;
      end
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) dat_d[p] = '0;
  endtask

  task automatic drain(input string name);
    for (int w = 0; w < 20 && sb.size() > 0; w++) begin
      @(posedge c_clk); #1;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL timeout_%s: %0d responses outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_quiet(input string name);
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rsp[p] != 2'd0 || dout[p] != 32'd0) begin
        errors++;
        $display("FAIL %s_port%0d: got resp %0d data %h, required resp 0 data 0",
                 name, p + 1, rsp[p], dout[p]);
      end
    end
  endtask

  task automatic reset_in_wait(input logic [1:7] rv, input string name);
    start(0, 4'd1, 32'd7, 32'd8, 2'd1, 32'd15, 0, 1'b0);
    operand2();
    reset = rv;
    #1;
    check_quiet({name, "_assert"});
    @(posedge c_clk); #1;
    reset = '0;
    repeat (6) begin
      @(posedge c_clk); #1;
      check_quiet({name, "_after"});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 4'd1,  32'h00000001, 32'h1FFFFFFF, 2'd1, 32'h20000000};
    vecs[1]  = '{0, 4'd1,  32'h1FFFFFFF, 32'h1FFFFFFF, 2'd1, 32'h3FFFFFFE};
    vecs[2]  = '{0, 4'd1,  32'h00000000, 32'h00000000, 2'd1, 32'h00000000};
    vecs[3]  = '{0, 4'd1,  32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h00000000};
    vecs[4]  = '{0, 4'd2,  32'h00000001, 32'h0000000F, 2'd2, 32'h00000000};
    vecs[5]  = '{0, 4'd2,  32'h0000000F, 32'h00000001, 2'd1, 32'h0000000E};
    vecs[6]  = '{0, 4'd3,  32'h00000001, 32'h00000000, 2'd2, 32'h00000000};
    vecs[7]  = '{0, 4'd4,  32'h00000001, 32'h00000000, 2'd2, 32'h00000000};
    vecs[8]  = '{0, 4'd5,  32'h00000001, 32'h00000021, 2'd1, 32'h00000002};
    vecs[9]  = '{0, 4'd6,  32'h80000000, 32'h0000001F, 2'd1, 32'h00000001};
    vecs[10] = '{1, 4'd15, 32'h12345678, 32'h00000001, 2'd2, 32'h00000000};
    vecs[11] = '{2, 4'd2,  32'h00000005, 32'h00000005, 2'd1, 32'h00000000};
    vecs[12] = '{3, 4'd5,  32'hFFFFFFFF, 32'hFFFFFFE4, 2'd1, 32'hFFFFFFF0};
    vecs[13] = '{3, 4'd6,  32'hF0000000, 32'h00000000, 2'd1, 32'hF0000000};

    reset = 7'b1111111;
    for (int p = 0; p < 4; p++) begin
      cmd_d[p]  = '0;
      dat_d[p]  = '0;
      pend_v[p] = 1'b0;
    end
    repeat (4) begin
      @(posedge c_clk); #1;
      check_quiet("reset_state");
    end
    reset = '0;

    for (int i = 0; i < 14; i++) begin
      start(vecs[i].port, vecs[i].cmd, vecs[i].op1, vecs[i].op2,
            vecs[i].resp, vecs[i].data, 0, 1'b1);
      operand2();
      drain($sformatf("vec%0d", i));
    end

    // All four ports contend for the add/sub unit.
    for (int p = 0; p < 4; p++) start(p, 4'd1, 32'd1, 32'd1, 2'd1, 32'd2, p, 1'b1);
    operand2();
    drain("contend_add");

    // Different units complete together.
    start(0, 4'd1, 32'd5, 32'd6, 2'd1, 32'd11, 0, 1'b1);
    start(1, 4'd5, 32'd3, 32'd2, 2'd1, 32'd12, 0, 1'b1);
    operand2();
    drain("add_and_shift");

    // Shift contention, invalid needs no unit, sub uses the idle adder.
    start(0, 4'd5, 32'h0000000F, 32'd4, 2'd1, 32'h000000F0, 0, 1'b1);
    start(1, 4'd6, 32'h0000F000, 32'd8, 2'd1, 32'h000000F0, 1, 1'b1);
    start(2, 4'd9, 32'd1,        32'd1, 2'd2, 32'h00000000, 0, 1'b1);
    start(3, 4'd2, 32'd10,       32'd3, 2'd1, 32'h00000007, 0, 1'b1);
    operand2();
    drain("mixed");

    // Next command on port 2 presented so it is sampled at the clearing edge.
    start(1, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5, 0, 1'b1);
    operand2();
    @(posedge c_clk); #1;
    start(1, 4'd2, 32'd9, 32'd4, 2'd1, 32'd5, 0, 1'b1);
    operand2();
    drain("back_to_back");
    repeat (2) @(posedge c_clk);
    #1;

    reset_in_wait(7'b1000000, "rst1_wait");
    reset_in_wait(7'b0000100, "rst5_wait");

    // Asynchronous clear while a response is on the outputs.
    start(0, 4'd1, 32'd2, 32'd2, 2'd1, 32'd4, 0, 1'b0);
    operand2();
    @(posedge c_clk); #1;
    checks++;
    if (out_resp1 != 2'd1 || out_data1 != 32'd4) begin
      errors++;
      $display("FAIL pre_async_resp: got resp %0d data %h, required resp 1 data 00000004",
               out_resp1, out_data1);
    end
    reset = 7'b0000001;
    #1;
    check_quiet("async_clear");
    @(posedge c_clk); #1;
    reset = '0;
    repeat (4) begin
      @(posedge c_clk); #1;
      check_quiet("async_after");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_1.md
# calc_1

Four-port, 32-bit integer calculator. Each of four independent requesters issues a command with two operands over consecutive cycles and receives a two-bit response plus a 32-bit result on its own output port. Internally, one add/subtract unit and one shift unit are shared across the ports by fixed-priority arbitration. The block sits behind the requester interfaces as a shared arithmetic resource.

## Interface
- No parameters.
- c_clk  in  1  single clock; all state changes on the rising edge.
- reset  in  7 [1:7]  asynchronous, active-high. Internal reset is the OR of all seven bits, so driving reset[1] alone fully resets the block.
- reqN_cmd_in (N=1..4)  in  4 [0:3]  command code, sampled with operand 1.
- reqN_data_in (N=1..4)  in  32 [0:31]  operand 1 in the command cycle, operand 2 in the next cycle.
- out_dataN (N=1..4)  out  32 [0:31]  result; valid only while out_respN = 1.
- out_respN (N=1..4)  out  2 [0:1]  response code:
  - 0 = none
  - 1 = success
  - 2 = overflow, underflow or invalid command
  - 3 = never driven
- Bit 0 is the MSB on all buses (big-endian numbering).

## Operation
- Command codes:
  - 0: no-op.
  - 1: add, op1+op2.
  - 2: subtract, op1−op2.
  - 5: shift left logical, op1 << op2[27:31].
  - 6: shift right logical, op1 >> op2[27:31].
  - 3, 4, 7–15: invalid.
- All arithmetic is unsigned 32-bit.
  - Add: carry-out gives resp 2, data 0.
  - Subtract: op2 > op1 gives resp 2, data 0.
  - Shifts never error. Only the low 5 bits of op2 are used; the upper bits are ignored.
- Invalid command: resp 2, data 0. It still consumes the operand-2 cycle.
- Per-port state machine:
  - IDLE → OP2 on a nonzero cmd; latch cmd and op1.
  - OP2 → WAIT; latch op2. The cmd input is ignored in this cycle.
  - WAIT → RESP when the required unit is granted, or immediately for invalid commands, which need no unit.
  - RESP → IDLE after one cycle.
- While a port is not in IDLE, its cmd input is ignored. A new command is accepted in the cycle after the response is presented.
- Arbitration: each unit serves at most one port per cycle. Adds/subtracts use the add/sub unit; shifts use the shift unit. Fixed priority is port 1 > 2 > 3 > 4. Both units may complete in the same cycle for different ports.
- When resp ≠ 1, out_dataN = 0.

## Timing
- Reset (async): every out_respN = 0, every out_dataN = 0, all ports IDLE, all latched operands cleared.
  - The reset state holds while any reset bit is high.
  - Operation resumes on the first rising edge after release.
  - Reset mid-operation abandons all in-flight commands; no response is produced for them.
- Uncontended latency:
  - Edge E0 samples cmd and op1.
  - Edge E1 samples op2.
  - Edge E2 registers the response.
  - out_respN/out_dataN are valid from E2 to E3 (exactly one cycle), and return to 0 at E3.
- Contention: each lost arbitration cycle delays the response by one cycle. The response is still held for exactly one cycle.
- Outputs are registered; no combinational input-to-output path.
- A new command presented exactly at E3 (the response clear edge) on the same port is accepted.

## Test plan
- Reset 4 cycles, then port 1 cmd 1, op1 0x00000001, op2 0x1FFFFFFF → out_resp1 = 1, out_data1 = 0x20000000 at E2; other ports resp 0.
- Port 1 add 0x1FFFFFFF + 0x1FFFFFFF → resp 1, data 0x3FFFFFFE. Add 0 + 0 → resp 1, data 0.
- Port 1 add 0xFFFFFFFF + 0x00000001 → resp 2, data 0. Subtract 0x00000001 − 0x0000000F → resp 2, data 0. Subtract 0xF − 0x1 → resp 1, data 0xE.
- Port 1 cmd 3, then cmd 4, each with op1 1 → resp 2, data 0, one cycle each. Shift left 0x1 by 0x21 (uses 1) → 0x2. Shift right 0x80000000 by 31 → 0x1.
- All four ports issue add 1+1 in the same cycle → responses of 2 on ports 1, 2, 3, 4 at E2, E2+1, E2+2, E2+3 respectively. Port 1 add plus port 2 shift issued together → both responses at E2.
- Assert reset[1] while port 1 is in WAIT → all outputs 0 immediately; no response after release. Reset via reset[5] alone → same behaviour.
